// File: rtl/ymdu.sv
// ymdu: iterative RISC-V M-extension multiply/divide unit with a start/busy/done handshake.
// Shift-add multiply and restoring divide, one bit per cycle, on operand magnitudes.
//
// state  | meaning
// S_IDLE | waiting for start; operands captured on acceptance
// S_CALC | WIDTH iterations of shift-add or restoring divide
// S_FIX  | sign correction and result select, loads o_z and pulses o_done
module ymdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_kill,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_z
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic               r_neg;
    logic               r_special;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;

    // operand decode at capture
    logic             w_div;
    logic             w_a_signed;
    logic             w_b_signed;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_ma;
    logic [WIDTH-1:0] w_mb;
    logic             w_b_zero;
    logic             w_ovf;
    logic             w_special;
    logic [WIDTH-1:0] w_forced;
    logic             w_neg;

    assign w_div      = i_op[2];
    assign w_a_signed = w_div ? ~i_op[0] : (i_op[1] ^ i_op[0]);
    assign w_b_signed = w_div ? ~i_op[0] : (i_op[1:0] == 2'b01);
    assign w_sa       = w_a_signed & i_a[WIDTH-1];
    assign w_sb       = w_b_signed & i_b[WIDTH-1];
    assign w_ma       = w_sa ? -i_a : i_a;
    assign w_mb       = w_sb ? -i_b : i_b;
    assign w_b_zero   = (i_b == '0);
    assign w_ovf      = w_div & ~i_op[0] & (i_a == MIN_NEG) & (i_b == '1);
    assign w_special  = w_div & (w_b_zero | w_ovf);
    assign w_forced   = w_b_zero ? (i_op[1] ? i_a : '1) : (i_op[1] ? '0 : MIN_NEG);
    // remainder takes the dividend's sign; everything else the product/quotient sign
    assign w_neg      = (w_div & i_op[1]) ? w_sa : (w_sa ^ w_sb);

    // iteration datapath: hi half is the partial product / remainder, lo half the
    // multiplier bits / dividend-then-quotient bits
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_rbit;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_result;

    assign w_hi     = r_acc[2*WIDTH-1:WIDTH];
    assign w_lo     = r_acc[WIDTH-1:0];
    assign w_addend = w_lo[0] ? r_opnd : '0;
    assign w_msum   = {1'b0, w_hi} + {1'b0, w_addend};
    assign w_rbit   = {w_hi, w_lo[WIDTH-1]};
    assign w_ge     = (w_rbit >= {1'b0, r_opnd});
    assign w_diff   = WIDTH'(w_rbit - {1'b0, r_opnd});
    assign w_prod   = r_neg ? -r_acc : r_acc;
    assign w_quo    = r_neg ? -w_lo : w_lo;
    assign w_rem    = r_neg ? -w_hi : w_hi;

    always_comb begin
        w_result = w_lo;
        if (r_special)
            w_result = w_lo;
        else if (!r_op[2])
            w_result = (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
        else
            w_result = r_op[1] ? w_rem : w_quo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_z       <= '0;
        end else begin
            o_done <= 1'b0;
            if (i_kill) begin
                r_state <= S_IDLE;
                o_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_op      <= i_op;
                            r_neg     <= w_neg;
                            r_special <= w_special;
                            r_cnt     <= '0;
                            o_busy    <= 1'b1;
                            if (w_special) begin
                                r_acc   <= {{WIDTH{1'b0}}, w_forced};
                                r_state <= S_FIX;
                            end else begin
                                r_state <= S_CALC;
                                if (w_div) begin
                                    r_acc  <= {{WIDTH{1'b0}}, w_ma};
                                    r_opnd <= w_mb;
                                end else begin
                                    r_acc  <= {{WIDTH{1'b0}}, w_mb};
                                    r_opnd <= w_ma;
                                end
                            end
                        end
                    end
                    S_CALC: begin
                        if (!r_op[2])
                            r_acc <= {w_msum, w_lo[WIDTH-1:1]};
                        else
                            r_acc <= {(w_ge ? w_diff : w_rbit[WIDTH-1:0]), w_lo[WIDTH-2:0], w_ge};
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == LAST)
                            r_state <= S_FIX;
                    end
                    S_FIX: begin
                        o_z     <= w_result;
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ymdu.sv
// Bench for ymdu: directed 32-bit vectors, handshake/kill/reset timing, and
// randomised 8-bit operands against an arithmetic reference model.
module tb_ymdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start32, kill32, busy32, done32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, z32;
    logic        start8, kill8, busy8, done8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, z8;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int ndone32 = 0, tot32 = 0, ndone8 = 0, tot8 = 0;
    logic pd32 = 1'b0, pd8 = 1'b0;

    typedef struct {logic [31:0] z; int cyc; int lat;} exp_t;
    exp_t q32[$];
    exp_t q8[$];

    ymdu #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .i_start(start32), .i_op(op32), .i_a(a32), .i_b(b32),
        .i_kill(kill32), .o_busy(busy32), .o_done(done32), .o_z(z32));

    ymdu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(start8), .i_op(op8), .i_a(a8), .i_b(b8),
        .i_kill(kill8), .o_busy(busy8), .o_done(done8), .o_z(z8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference: RISC-V M semantics on w-bit operands using wide signed arithmetic
    function automatic logic [31:0] refm(input int w, input logic [2:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] au, bu, as, bs, r, mn;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        au = {34'b0, a & mask};
        bu = {34'b0, b & mask};
        as = a[w-1] ? au - (66'sd1 <<< w) : au;
        bs = b[w-1] ? bu - (66'sd1 <<< w) : bu;
        mn = -(66'sd1 <<< (w - 1));
        case (op)
            3'd0:    r = as * bs;
            3'd1:    r = (as * bs) >>> w;
            3'd2:    r = (as * bu) >>> w;
            3'd3:    r = (au * bu) >>> w;
            3'd4:    r = (bu == 0) ? -66'sd1 : ((as == mn && bs == -66'sd1) ? as : as / bs);
            3'd5:    r = (bu == 0) ? -66'sd1 : au / bu;
            3'd6:    r = (bu == 0) ? as : ((as == mn && bs == -66'sd1) ? 66'sd0 : as % bs);
            default: r = (bu == 0) ? au : au % bu;
        endcase
        return r[31:0] & mask;
    endfunction

    always @(negedge clk) begin
        if (done32) begin
            check("done32_gap", {31'b0, pd32}, 32'd0);
            if (q32.size() == 0)
                check("done32_unexpected", {31'b0, done32}, 32'd0);
            else begin
                check("z32", z32, q32[0].z);
                check("lat32", 32'(cyc - q32[0].cyc), 32'(q32[0].lat));
                void'(q32.pop_front());
            end
            ndone32++;
        end
        pd32 = done32;
    end

    always @(negedge clk) begin
        if (done8) begin
            check("done8_gap", {31'b0, pd8}, 32'd0);
            if (q8.size() == 0)
                check("done8_unexpected", {31'b0, done8}, 32'd0);
            else begin
                check("z8", {24'b0, z8}, q8[0].z);
                check("lat8", 32'(cyc - q8[0].cyc), 32'(q8[0].lat));
                void'(q8.pop_front());
            end
            ndone8++;
        end
        pd8 = done8;
    end

    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ez, input int lat);
        q32.push_back(exp_t'{ez, cyc, lat});
        tot32++;
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        check("busy32_c1", {31'b0, busy32}, 32'd1);
        repeat (lat - 1) @(posedge clk);
        #1;
        check("busy32_at_done", {31'b0, busy32}, 32'd0);
        check("done32_at_lat", {31'b0, done32}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [31:0] ez, input int lat);
        q8.push_back(exp_t'{ez, cyc, lat});
        tot8++;
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        check("busy8_c1", {31'b0, busy8}, 32'd1);
        repeat (lat - 1) @(posedge clk);
        #1;
        check("busy8_at_done", {31'b0, busy8}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] rop;
        logic [7:0] ra, rb;
        int         rsel;
        logic       rspec;

        rst_n = 1'b0;
        start32 = 1'b0; kill32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8 = 1'b0; kill8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy32", {31'b0, busy32}, 32'd0);
        check("rst_done32", {31'b0, done32}, 32'd0);
        check("rst_z32", z32, 32'd0);
        check("rst_busy8", {31'b0, busy8}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run32(3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 34);
        run32(3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34);
        run32(3'b011, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 34);
        run32(3'b010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34);
        run32(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run32(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run32(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
        run32(3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 34);
        run32(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run32(3'b111, 32'd5, 32'd0, 32'd5, 2);
        run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
        run32(3'b101, 32'd100, 32'd7, 32'd14, 34);

        // kill mid-CALC: busy drops next cycle, no done, z keeps 14
        start32 = 1'b1; op32 = 3'b000; a32 = 32'd123; b32 = 32'd456;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        kill32 = 1'b1;
        @(posedge clk); #1;
        kill32 = 1'b0;
        check("kill_busy", {31'b0, busy32}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("kill_no_done", ndone32, tot32);
        check("kill_z_held", z32, 32'd14);

        kill32 = 1'b1; start32 = 1'b1;
        @(posedge clk); #1;
        kill32 = 1'b0; start32 = 1'b0;
        check("kill_start_idle", {31'b0, busy32}, 32'd0);

        // asynchronous reset mid-CALC of a DIVU
        start32 = 1'b1; op32 = 3'b101; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy32}, 32'd0);
        check("arst_done", {31'b0, done32}, 32'd0);
        check("arst_z", z32, 32'd0);
        #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("arst_no_done", ndone32, tot32);
        run32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);

        // start held high: accepted at relative cycles 0, 34, 68; cycle-10 operands ignored
        start32 = 1'b1; op32 = 3'b000; a32 = 32'd7; b32 = 32'd9;
        q32.push_back(exp_t'{refm(32, 3'b000, 32'd7, 32'd9), cyc, 34});
        tot32++;
        for (int k = 1; k <= 69; k++) begin
            @(posedge clk); #1;
            if (k == 10) begin
                op32 = 3'b101; a32 = 32'd999; b32 = 32'd5;
            end
            if (k == 34) begin
                op32 = 3'b101; a32 = 32'd100; b32 = 32'd7;
                q32.push_back(exp_t'{refm(32, 3'b101, 32'd100, 32'd7), cyc, 34});
                tot32++;
            end
            if (k == 68) begin
                op32 = 3'b110; a32 = 32'hFFFF_FFF9; b32 = 32'd2;
                q32.push_back(exp_t'{refm(32, 3'b110, 32'hFFFF_FFF9, 32'd2), cyc, 34});
                tot32++;
            end
        end
        start32 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("handshake_done_count", ndone32, tot32);

        for (int i = 0; i < 64; i++) begin
            rop  = 3'(i % 8);
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rsel = $urandom_range(0, 7);
            if (rsel == 0) rb = 8'h00;
            if (rsel == 1) begin
                ra = 8'h80; rb = 8'hFF;
            end
            rspec = rop[2] && (rb == 8'h00 || (!rop[0] && ra == 8'h80 && rb == 8'hFF));
            run8(rop, ra, rb, refm(8, rop, {24'b0, ra}, {24'b0, rb}), rspec ? 2 : 10);
        end
        repeat (5) @(posedge clk);
        #1;
        check("w8_done_count", ndone8, tot8);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ymdu.md
# ymdu

Iterative multiply/divide unit: the parametrised successor to the combinational yAlu. It executes the RISC-V M-extension operations over several cycles through a start/busy/done handshake. It sits beside yAlu in the EX stage: the controller stalls PC/IF while `busy` is high and selects `z` into writeback on `done`.

## Interface
- `WIDTH`, default 32: operand/result width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request; sampled only when idle.
- `op`  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  WIDTH  rs1 operand; captured when `start` is accepted.
- `b`  in  WIDTH  rs2 operand; captured when `start` is accepted.
- `kill`  in  1  synchronous abort (pipeline flush / interrupt).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `z` is valid in that cycle.
- `z`  out  WIDTH  result; held until the next `done`.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 with no `kill` captures `a`, `b`, `op`, clears the iteration counter and goes to CALC.
  - Exception: special divide cases go straight to FIX.
- Operand capture:
  - Signed ops convert operands to magnitudes and record the result sign.
  - Signed ops are MULH (a, b signed), MULHSU (a signed only), DIV/REM (both signed). MUL is sign-agnostic; it uses the low half.
- CALC, multiply:
  - Shift-add, one bit of `b` per cycle.
  - 2·WIDTH-bit accumulator.
- CALC, divide:
  - Restoring division, one quotient bit per cycle.
  - WIDTH-bit remainder plus a borrow bit.
- CALC exit: after exactly WIDTH iterations, go to FIX.
- FIX:
  - Apply two's-complement sign correction.
  - Select the result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - Load `z`, pulse `done` on the next cycle, go to IDLE.
- Remainder sign follows `a` (truncating division).
- Special cases, detected at capture; IDLE→FIX directly with forced result:
  - `b`=0, DIV/DIVU → `z` = all ones.
  - `b`=0, REM/REMU → `z` = `a`.
  - DIV with `a`=most-negative, `b`=all ones → `z` = most-negative.
  - REM with `a`=most-negative, `b`=all ones → `z` = 0.
- `start` while busy: ignored; no queuing.
- `kill`:
  - Any state → IDLE at the next edge.
  - No `done`; `z` unchanged.
  - `kill` and `start` together in IDLE: `kill` wins, nothing accepted.
- Reset (any time, including mid-operation):
  - State IDLE, counter 0.
  - `busy`=0, `done`=0, `z`=0.

## Timing
- Cycle numbering: cycle 0 is the cycle in which `start` is accepted.
- Normal ops:
  - `busy`=1 in cycles 1..WIDTH+1.
  - `done`=1 and `busy`=0 in cycle WIDTH+2 (latency WIDTH+2).
- Special divide cases:
  - `busy`=1 in cycle 1.
  - `done` in cycle 2.
- Back-to-back: `start` may be asserted in the `done` cycle and is accepted, so throughput is one op per WIDTH+2 cycles.
- `busy`, `done` and `z` are registered outputs with no combinational path from inputs.
- `done` is never high in two consecutive cycles.
- Inputs other than `start`/`kill` are don't-care outside cycle 0.

## Test plan
- Reset:
  - Pulse `rst_n` low mid-CALC of a DIVU → `busy`, `done`, `z` = 0 immediately.
  - No `done` afterwards.
  - The next `start` works normally.
- Multiply family, WIDTH=32, `a`=0xFFFFFFFE (−2), `b`=0x00000003:
  - MUL → 0xFFFFFFFA.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000002.
  - MULHSU → 0xFFFFFFFF.
  - Each `done` lands in cycle 34.
- Divide family, `a`=0xFFFFFFF9 (−7), `b`=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
- Special cases, each with `done` in cycle 2:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Handshake:
  - `start` held high throughout → ops accepted in cycles 0, 34, 68.
  - A `start` with different operands in cycle 10 is ignored.
  - `kill` in cycle 15 → `busy` low in cycle 16, no `done`, `z` keeps its previous value.
- Parametrisation: WIDTH=8 with random signed/unsigned operands vs. a reference model → all eight ops match, latency 10.
